clock_set_ctrl: RTL and testbench

Mode and sequencing controller for the 24-hour time-of-day counter. Converts debounced front-panel buttons into a time-set procedure: freeze the counter, edit hour/minute/second, then load the edited value in one cycle. Also holds an alarm time and raises a timed alarm output when the running time reaches it. Sits between the button debouncers and the time counter; everything runs on the 1 kHz kh_clk.

---
 rtl/clock_set_ctrl.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_clock_set_ctrl.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_set_ctrl.sv
// Mode and sequencing controller for the 24-hour time-of-day counter.
// Turns debounced front-panel buttons into a time-set procedure:
//   * freeze the counter,
//   * edit the hour, minute and second fields,
//   * load the edited value into the counter in a single cycle.
// It also holds an alarm time (hh:mm) and raises a timed alarm output when the
// running time reaches it.
//
// Ports
//   kh_clk      1 kHz clock
//   reset       asynchronous, active-high reset
//   btn_mode    single-cycle pulse, advances the time-set sequence
//   btn_alarm   single-cycle pulse, advances the alarm-set sequence
//   btn_inc     debounced level, increments the field being edited (auto-repeat)
//   alarm_en    level, enables the alarm compare
//   cur_time    running time {hr[16:12], min[11:6], sec[5:0]}
//   run_en      counter count enable
//   load_en     one-cycle load strobe to the counter
//   load_time   value to load, same packing as cur_time
//   edit_field  field being edited: 0 none, 1 hr, 2 min, 3 sec
//   alarm_time  stored alarm time, sec field always 0
//   alarm_out   alarm active
module clock_set_ctrl #(
  parameter int unsigned TIMEOUT      = 10000,
  parameter int unsigned REPEAT_DELAY = 500,
  parameter int unsigned REPEAT_RATE  = 100,
  parameter int unsigned ALARM_LEN    = 30000
) (
  input  logic        kh_clk,
  input  logic        reset,
  input  logic        btn_mode,
  input  logic        btn_alarm,
  input  logic        btn_inc,
  input  logic        alarm_en,
  input  logic [16:0] cur_time,
  output logic        run_en,
  output logic        load_en,
  output logic [16:0] load_time,
  output logic [1:0]  edit_field,
  output logic [16:0] alarm_time,
  output logic        alarm_out
);

  localparam int unsigned RepMax = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned TW     = $clog2(TIMEOUT + 1);
  localparam int unsigned RW     = $clog2(RepMax + 1);
  localparam int unsigned AW     = $clog2(ALARM_LEN + 1);

  typedef enum logic [2:0] {
    StRun,
    StSetHr,
    StSetMin,
    StSetSec,
    StCommit,
    StAlmHr,
    StAlmMin
  } state_e;

  state_e          state_q, state_d;
  logic [16:0]     edit_q, edit_d;
  logic [16:0]     alarm_time_q, alarm_time_d;
  logic [TW-1:0]   idle_q, idle_d;
  logic [RW-1:0]   rep_cnt_q, rep_cnt_d;
  logic            rep_phase_q, rep_phase_d;
  logic            inc_prev_q;
  logic            match_prev_q;
  logic            alarm_out_q, alarm_out_d;
  logic [AW-1:0]   alarm_cnt_q, alarm_cnt_d;

  logic            inc_rise;
  logic            rep_fire;
  logic            inc_req;
  logic            match;
  logic            fire;
  logic            consume;
  logic            mode_ev;
  logic            alarm_ev;
  logic            inc_ev;
  logic            activity;
  logic            is_edit;
  logic [4:0]      hr_nxt;
  logic [5:0]      min_nxt;
  logic [5:0]      sec_nxt;

  // Button event decode.
  assign inc_rise = btn_inc & ~inc_prev_q;
  assign inc_req  = inc_rise | rep_fire;
  assign activity = btn_mode | btn_alarm | btn_inc;

  // An event that clears an active alarm is swallowed entirely.
  assign consume  = alarm_out_q & (btn_mode | btn_alarm | inc_req);
  assign mode_ev  = btn_mode & ~consume;
  assign alarm_ev = btn_alarm & ~consume;
  assign inc_ev   = inc_req & ~consume;

  assign is_edit = (state_q == StSetHr) || (state_q == StSetMin) || (state_q == StSetSec) ||
                   (state_q == StAlmHr) || (state_q == StAlmMin);

  // Field increments wrap without carrying into the neighbouring field.
  assign hr_nxt  = (edit_q[16:12] >= 5'd23) ? 5'd0 : edit_q[16:12] + 5'd1;
  assign min_nxt = (edit_q[11:6] >= 6'd59) ? 6'd0 : edit_q[11:6] + 6'd1;
  assign sec_nxt = (edit_q[5:0] >= 6'd59) ? 6'd0 : edit_q[5:0] + 6'd1;

  // Auto-repeat: the first repeat comes REPEAT_DELAY cycles after the rise,
  // then one every REPEAT_RATE cycles while the button stays held.
  always_comb begin
    rep_fire    = 1'b0;
    rep_cnt_d   = rep_cnt_q;
    rep_phase_d = rep_phase_q;
    if (!btn_inc) begin
      rep_cnt_d   = '0;
      rep_phase_d = 1'b0;
    end else if (inc_rise) begin
      rep_cnt_d   = RW'(1);
      rep_phase_d = 1'b0;
    end else if (!rep_phase_q && (rep_cnt_q == RW'(REPEAT_DELAY))) begin
      rep_fire    = 1'b1;
      rep_cnt_d   = RW'(1);
      rep_phase_d = 1'b1;
    end else if (rep_phase_q && (rep_cnt_q == RW'(REPEAT_RATE))) begin
      rep_fire    = 1'b1;
      rep_cnt_d   = RW'(1);
    end else begin
      rep_cnt_d   = rep_cnt_q + RW'(1);
    end
  end

  // Sequencing FSM, edit register and alarm-time register.
  always_comb begin
    state_d      = state_q;
    edit_d       = edit_q;
    alarm_time_d = alarm_time_q;

    if (!is_edit || activity) begin
      idle_d = '0;
    end else begin
      idle_d = idle_q + TW'(1);
    end

    unique case (state_q)
      StRun: begin
        if (mode_ev) begin
          state_d = StSetHr;
          edit_d  = cur_time;
        end else if (alarm_ev) begin
          state_d = StAlmHr;
          edit_d  = alarm_time_q;
        end
      end
      StSetHr: begin
        if (mode_ev) begin
          state_d = StSetMin;
        end else if (inc_ev) begin
          edit_d[16:12] = hr_nxt;
        end
      end
      StSetMin: begin
        if (mode_ev) begin
          state_d = StSetSec;
        end else if (inc_ev) begin
          edit_d[11:6] = min_nxt;
        end
      end
      StSetSec: begin
        if (mode_ev) begin
          state_d = StCommit;
        end else if (inc_ev) begin
          edit_d[5:0] = sec_nxt;
        end
      end
      StCommit: begin
        state_d = StRun;
      end
      StAlmHr: begin
        if (alarm_ev) begin
          state_d = StAlmMin;
        end else if (inc_ev) begin
          edit_d[16:12] = hr_nxt;
        end
      end
      StAlmMin: begin
        if (alarm_ev) begin
          state_d      = StRun;
          alarm_time_d = {edit_q[16:6], 6'd0};
        end else if (inc_ev) begin
          edit_d[11:6] = min_nxt;
        end
      end
      default: begin
        state_d = StRun;
      end
    endcase

    // Abandon an idle edit; nothing is loaded or stored.
    if (is_edit && !activity && (idle_q == TW'(TIMEOUT - 1))) begin
      state_d = StRun;
      idle_d  = '0;
    end
  end

  // Alarm compare runs in every state; only a rising match fires.
  assign match = alarm_en && (cur_time[16:6] == alarm_time_q[16:6]) && (cur_time[5:0] == 6'd0);
  assign fire  = match & ~match_prev_q;

  always_comb begin
    alarm_out_d = alarm_out_q;
    alarm_cnt_d = alarm_cnt_q;
    if (fire) begin
      alarm_out_d = 1'b1;
      alarm_cnt_d = AW'(ALARM_LEN);
    end else if (alarm_out_q) begin
      if (!alarm_en || consume || (alarm_cnt_q == AW'(1))) begin
        alarm_out_d = 1'b0;
        alarm_cnt_d = '0;
      end else begin
        alarm_cnt_d = alarm_cnt_q - AW'(1);
      end
    end
  end

  always_ff @(posedge kh_clk or posedge reset) begin
    if (reset) begin
      state_q      <= StRun;
      edit_q       <= '0;
      alarm_time_q <= '0;
      idle_q       <= '0;
      rep_cnt_q    <= '0;
      rep_phase_q  <= 1'b0;
      inc_prev_q   <= 1'b0;
      // Starting high blocks a spurious fire at 00:00:00 straight out of reset.
      match_prev_q <= 1'b1;
      alarm_out_q  <= 1'b0;
      alarm_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      edit_q       <= edit_d;
      alarm_time_q <= alarm_time_d;
      idle_q       <= idle_d;
      rep_cnt_q    <= rep_cnt_d;
      rep_phase_q  <= rep_phase_d;
      inc_prev_q   <= btn_inc;
      match_prev_q <= match;
      alarm_out_q  <= alarm_out_d;
      alarm_cnt_q  <= alarm_cnt_d;
    end
  end

  // Outputs decoded from the current state.
  always_comb begin
    run_en     = 1'b1;
    load_en    = 1'b0;
    load_time  = '0;
    edit_field = 2'd0;
    unique case (state_q)
      StSetHr: begin
        run_en     = 1'b0;
        edit_field = 2'd1;
      end
      StSetMin: begin
        run_en     = 1'b0;
        edit_field = 2'd2;
      end
      StSetSec: begin
        run_en     = 1'b0;
        edit_field = 2'd3;
      end
      StCommit: begin
        run_en    = 1'b0;
        load_en   = 1'b1;
        load_time = edit_q;
      end
      StAlmHr: begin
        edit_field = 2'd1;
      end
      StAlmMin: begin
        edit_field = 2'd2;
      end
      default: begin
        run_en = 1'b1;
      end
    endcase
  end

  assign alarm_time = alarm_time_q;
  assign alarm_out  = alarm_out_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
module tb_clock_set_ctrl;

  logic        kh_clk;
  logic        reset;
  logic        btn_mode;
  logic        btn_alarm;
  logic        btn_inc;
  logic        alarm_en;
  logic [16:0] cur_time;
  logic        run_en;
  logic        load_en;
  logic [16:0] load_time;
  logic [1:0]  edit_field;
  logic [16:0] alarm_time;
  logic        alarm_out;

  int n_tests;
  int n_fail;
  logic [16:0] exp_q[$];

  clock_set_ctrl #(
    .TIMEOUT     (20),
    .REPEAT_DELAY(5),
    .REPEAT_RATE (2),
    .ALARM_LEN   (8)
  ) dut (
    .kh_clk    (kh_clk),
    .reset     (reset),
    .btn_mode  (btn_mode),
    .btn_alarm (btn_alarm),
    .btn_inc   (btn_inc),
    .alarm_en  (alarm_en),
    .cur_time  (cur_time),
    .run_en    (run_en),
    .load_en   (load_en),
    .load_time (load_time),
    .edit_field(edit_field),
    .alarm_time(alarm_time),
    .alarm_out (alarm_out)
  );

  initial kh_clk = 1'b0;
  always #5 kh_clk = ~kh_clk;

  function automatic logic [16:0] tm(input logic [4:0] h, input logic [5:0] m,
                                     input logic [5:0] s);
    return {h, m, s};
  endfunction

  // Advance one edge, sample 1 time unit later, and score any load strobe.
  task automatic tick();
    logic [16:0] exp;
    @(posedge kh_clk);
    #1;
    if (load_en === 1'b1) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL load_unexpected: load_en=1 load_time=%h, required no load", load_time);
      end else begin
        exp = exp_q.pop_front();
        if (load_time !== exp) begin
          n_fail++;
          $display("FAIL load_time: got %h, required %h", load_time, exp);
        end
      end
    end
  endtask

  task automatic press_mode();
    btn_mode = 1'b1;
    tick();
    btn_mode = 1'b0;
    tick();
  endtask

  task automatic press_alarm();
    btn_alarm = 1'b1;
    tick();
    btn_alarm = 1'b0;
    tick();
  endtask

  task automatic tap();
    btn_inc = 1'b1;
    tick();
    btn_inc = 1'b0;
    tick();
  endtask

  task automatic check_no_pending(input string name);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s: %0d expected loads never seen, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; btn_mode = 1'b0; btn_alarm = 1'b0; btn_inc = 1'b0;
    alarm_en = 1'b0; cur_time = '0;
    tick();
    tick();
    n_tests++;
    if ({run_en, load_en, load_time, edit_field, alarm_time, alarm_out} !==
        {1'b1, 1'b0, 17'd0, 2'd0, 17'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state: run=%b load=%b lt=%h ef=%0d at=%h ao=%b, required 1 0 0 0 0 0",
               run_en, load_en, load_time, edit_field, alarm_time, alarm_out);
    end
    reset = 1'b0;
    tick();
    n_tests++;
    if (run_en !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_run: got %b, required 1", run_en);
    end
  endtask

  task automatic test_set_sequence();
    cur_time = tm(5'd12, 6'd34, 6'd56);
    btn_mode = 1'b1;
    tick();
    n_tests++;
    if (run_en !== 1'b0 || edit_field !== 2'd1) begin
      n_fail++;
      $display("FAIL set_hr_entry: run=%b ef=%0d, required 0 1", run_en, edit_field);
    end
    btn_mode = 1'b0;
    tick();
    press_mode();
    n_tests++;
    if (run_en !== 1'b0 || edit_field !== 2'd2) begin
      n_fail++;
      $display("FAIL set_min_entry: run=%b ef=%0d, required 0 2", run_en, edit_field);
    end
    press_mode();
    n_tests++;
    if (run_en !== 1'b0 || edit_field !== 2'd3) begin
      n_fail++;
      $display("FAIL set_sec_entry: run=%b ef=%0d, required 0 3", run_en, edit_field);
    end
    exp_q.push_back(tm(5'd12, 6'd34, 6'd56));
    btn_mode = 1'b1;
    tick();
    n_tests++;
    if (load_en !== 1'b1 || run_en !== 1'b0) begin
      n_fail++;
      $display("FAIL commit_cycle: load=%b run=%b, required 1 0", load_en, run_en);
    end
    btn_mode = 1'b0;
    tick();
    n_tests++;
    if (run_en !== 1'b1 || load_en !== 1'b0 || edit_field !== 2'd0) begin
      n_fail++;
      $display("FAIL after_commit: run=%b load=%b ef=%0d, required 1 0 0",
               run_en, load_en, edit_field);
    end
    check_no_pending("set_sequence_loads");
  endtask

  task automatic test_wrap();
    cur_time = tm(5'd22, 6'd59, 6'd10);
    press_mode();
    tap();
    tap();
    press_mode();
    tap();
    press_mode();
    exp_q.push_back(tm(5'd0, 6'd0, 6'd10));
    press_mode();
    check_no_pending("wrap_loads");
  endtask

  task automatic test_repeat();
    cur_time = tm(5'd5, 6'd0, 6'd20);
    press_mode();
    press_mode();
    btn_inc = 1'b1;
    repeat (10) tick();
    btn_inc = 1'b0;
    tick();
    press_mode();
    exp_q.push_back(tm(5'd5, 6'd4, 6'd20));
    press_mode();
    check_no_pending("repeat_loads");
  endtask

  task automatic test_timeout();
    cur_time = tm(5'd10, 6'd20, 6'd30);
    press_mode();
    press_mode();
    press_mode();
    btn_inc = 1'b1;
    tick();
    btn_inc = 1'b0;
    repeat (19) tick();
    n_tests++;
    if (run_en !== 1'b0 || edit_field !== 2'd3) begin
      n_fail++;
      $display("FAIL timeout_early: run=%b ef=%0d, required 0 3", run_en, edit_field);
    end
    tick();
    n_tests++;
    if (run_en !== 1'b1 || edit_field !== 2'd0) begin
      n_fail++;
      $display("FAIL timeout_abort: run=%b ef=%0d, required 1 0", run_en, edit_field);
    end
    check_no_pending("timeout_loads");
  endtask

  task automatic test_simultaneous();
    cur_time = tm(5'd10, 6'd20, 6'd30);
    btn_mode = 1'b1;
    btn_inc  = 1'b1;
    tick();
    n_tests++;
    if (edit_field !== 2'd1 || run_en !== 1'b0) begin
      n_fail++;
      $display("FAIL mode_inc_entry: ef=%0d run=%b, required 1 0", edit_field, run_en);
    end
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    tick();
    press_mode();
    press_mode();
    exp_q.push_back(tm(5'd10, 6'd20, 6'd30));
    press_mode();
    // Mode and alarm together from RUN: mode wins (SET_HR freezes the counter).
    btn_mode  = 1'b1;
    btn_alarm = 1'b1;
    tick();
    n_tests++;
    if (edit_field !== 2'd1 || run_en !== 1'b0) begin
      n_fail++;
      $display("FAIL mode_alarm_priority: ef=%0d run=%b, required 1 0", edit_field, run_en);
    end
    btn_mode  = 1'b0;
    btn_alarm = 1'b0;
    tick();
    press_mode();
    press_mode();
    exp_q.push_back(tm(5'd10, 6'd20, 6'd30));
    press_mode();
    check_no_pending("simultaneous_loads");
  endtask

  task automatic test_alarm();
    press_alarm();
    n_tests++;
    if (edit_field !== 2'd1 || run_en !== 1'b1) begin
      n_fail++;
      $display("FAIL alm_hr_entry: ef=%0d run=%b, required 1 1", edit_field, run_en);
    end
    repeat (7) tap();
    press_alarm();
    repeat (30) tap();
    press_alarm();
    n_tests++;
    if (alarm_time !== tm(5'd7, 6'd30, 6'd0) || edit_field !== 2'd0) begin
      n_fail++;
      $display("FAIL alarm_store: at=%h ef=%0d, required %h 0",
               alarm_time, edit_field, tm(5'd7, 6'd30, 6'd0));
    end
    alarm_en = 1'b1;
    cur_time = tm(5'd7, 6'd29, 6'd59);
    tick();
    n_tests++;
    if (alarm_out !== 1'b0) begin
      n_fail++;
      $display("FAIL alarm_premature: got %b, required 0", alarm_out);
    end
    cur_time = tm(5'd7, 6'd30, 6'd0);
    tick();
    n_tests++;
    if (alarm_out !== 1'b1) begin
      n_fail++;
      $display("FAIL alarm_fire: got %b, required 1", alarm_out);
    end
    repeat (7) tick();
    n_tests++;
    if (alarm_out !== 1'b1) begin
      n_fail++;
      $display("FAIL alarm_hold: got %b, required 1", alarm_out);
    end
    tick();
    n_tests++;
    if (alarm_out !== 1'b0) begin
      n_fail++;
      $display("FAIL alarm_expire: got %b, required 0", alarm_out);
    end
    cur_time = tm(5'd7, 6'd30, 6'd1);
    tick();
    cur_time = tm(5'd7, 6'd30, 6'd0);
    tick();
    n_tests++;
    if (alarm_out !== 1'b1) begin
      n_fail++;
      $display("FAIL alarm_refire: got %b, required 1", alarm_out);
    end
    btn_mode = 1'b1;
    tick();
    btn_mode = 1'b0;
    n_tests++;
    if (alarm_out !== 1'b0 || edit_field !== 2'd0 || run_en !== 1'b1) begin
      n_fail++;
      $display("FAIL alarm_btn_consume: ao=%b ef=%0d run=%b, required 0 0 1",
               alarm_out, edit_field, run_en);
    end
    tick();
    cur_time = tm(5'd7, 6'd30, 6'd1);
    tick();
    cur_time = tm(5'd7, 6'd30, 6'd0);
    tick();
    alarm_en = 1'b0;
    tick();
    n_tests++;
    if (alarm_out !== 1'b0) begin
      n_fail++;
      $display("FAIL alarm_en_clear: got %b, required 0", alarm_out);
    end
    check_no_pending("alarm_loads");
  endtask

  task automatic test_reset_mid_edit();
    cur_time = tm(5'd0, 6'd0, 6'd0);
    press_alarm();
    tap();
    press_alarm();
    n_tests++;
    if (edit_field !== 2'd2) begin
      n_fail++;
      $display("FAIL alm_min_entry: ef=%0d, required 2", edit_field);
    end
    #2;
    reset = 1'b1;
    #1;
    n_tests++;
    if (alarm_time !== 17'd0 || edit_field !== 2'd0 || run_en !== 1'b1 || load_en !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: at=%h ef=%0d run=%b load=%b, required 0 0 1 0",
               alarm_time, edit_field, run_en, load_en);
    end
    tick();
    reset    = 1'b0;
    alarm_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_tests++;
      if (alarm_out !== 1'b0) begin
        n_fail++;
        $display("FAIL no_fire_at_midnight[%0d]: got %b, required 0", i, alarm_out);
      end
    end
    check_no_pending("reset_mid_edit_loads");
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_set_sequence();
    test_wrap();
    test_repeat();
    test_timeout();
    test_simultaneous();
    test_alarm();
    test_reset_mid_edit();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
